// File: rtl/led_chaser.sv
// led_chaser: moves a single lit LED one position per tick, ping-ponging or wrapping at the ends
module led_chaser #(
  parameter int N  = 16,
  parameter int PW = $clog2(N)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          tick,
  input  logic          en,
  input  logic          bounce,
  input  logic          dir,
  output logic [N-1:0]  led,
  output logic [PW-1:0] pos,
  output logic          at_end
);
  typedef enum logic [1:0] {IDLE, UP, DOWN} state_t;
  localparam logic [PW-1:0] LAST = PW'(N - 1);
  localparam logic [PW-1:0] ONE  = PW'(1);
  state_t state, state_n;
  logic [PW-1:0] pos_n;
  logic step;
  always_comb begin
    state_n = state;
    pos_n   = pos;
    step    = 1'b0;
    if (state == IDLE) state_n = en ? (dir ? DOWN : UP) : IDLE;
    else if (!en) state_n = IDLE;
    else if (tick) begin
      step = 1'b1;
      if (state == UP) begin
        pos_n   = pos != LAST ? pos + ONE : bounce ? LAST - ONE : '0;
        state_n = pos == LAST && bounce ? DOWN : UP;
      end else begin
        pos_n   = pos != '0 ? pos - ONE : bounce ? ONE : LAST;
        state_n = pos == '0 && bounce ? UP : DOWN;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      pos    <= '0;
      led    <= N'(1);
      at_end <= 1'b0;
    end else begin
      state  <= state_n;
      pos    <= pos_n;
      led    <= N'(1) << pos_n;
      at_end <= step && (pos_n == '0 || pos_n == LAST);
    end
  end
endmodule

// File: tb/tb_led_chaser.sv
// tb_led_chaser: scoreboard bench for an 8-LED and a 2-LED chaser
module tb_led_chaser;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_a, tick_a, en_a, bounce_a, dir_a;
  logic [7:0] led_a;
  logic [2:0] pos_a;
  logic end_a;
  logic reset_b, tick_b, en_b, bounce_b, dir_b;
  logic [1:0] led_b;
  logic [0:0] pos_b;
  logic end_b;

  led_chaser #(.N(8)) dut_a (
    .clk(clk), .reset(reset_a), .tick(tick_a), .en(en_a), .bounce(bounce_a), .dir(dir_a),
    .led(led_a), .pos(pos_a), .at_end(end_a)
  );
  led_chaser #(.N(2)) dut_b (
    .clk(clk), .reset(reset_b), .tick(tick_b), .en(en_b), .bounce(bounce_b), .dir(dir_b),
    .led(led_b), .pos(pos_b), .at_end(end_b)
  );

  typedef struct {logic r, t, en, b, d; int p; logic ae;} row_t;
  typedef struct {int p; logic ae;} exp_t;
  exp_t q[$];
  int errors = 0;
  int checks = 0;

  function automatic row_t mk(int r, int t, int en, int b, int d, int p, int ae);
    row_t w;
    w.r = r[0]; w.t = t[0]; w.en = en[0]; w.b = b[0]; w.d = d[0]; w.p = p; w.ae = ae[0];
    return w;
  endfunction

  task automatic drive_a(input row_t w);
    {reset_a, tick_a, en_a, bounce_a, dir_a} = {w.r, w.t, w.en, w.b, w.d};
    q.push_back('{w.p, w.ae});
    @(posedge clk); #1;
  endtask

  task automatic drive_b(input row_t w);
    {reset_b, tick_b, en_b, bounce_b, dir_b} = {w.r, w.t, w.en, w.b, w.d};
    q.push_back('{w.p, w.ae});
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    row_t rows[$];
    exp_t e;
    rows.push_back(mk(1, 1, 1, 1, 1, 0, 0));
    rows.push_back(mk(0, 1, 0, 0, 0, 0, 0));
    rows.push_back(mk(0, 1, 0, 1, 1, 0, 0));
    foreach (rows[i]) begin
      drive_a(rows[i]);
      e = q.pop_front();
      checks++;
      if (pos_a !== 3'(e.p) || led_a !== 8'(1 << e.p) || end_a !== e.ae) begin
        errors++;
        $display("FAIL reset[%0d]: got pos=%0d led=%b at_end=%b, want pos=%0d led=%b at_end=%b",
                 i, pos_a, led_a, end_a, e.p, 8'(1 << e.p), e.ae);
      end
    end
  endtask

  task automatic test_bounce();
    int seq[15] = '{1, 2, 3, 4, 5, 6, 7, 6, 5, 4, 3, 2, 1, 0, 1};
    row_t rows[$];
    exp_t e;
    rows.push_back(mk(1, 0, 0, 0, 0, 0, 0));
    rows.push_back(mk(0, 0, 1, 1, 0, 0, 0));
    foreach (seq[i]) rows.push_back(mk(0, 1, 1, 1, 0, seq[i], int'(seq[i] == 0 || seq[i] == 7)));
    foreach (rows[i]) begin
      drive_a(rows[i]);
      e = q.pop_front();
      checks++;
      if (pos_a !== 3'(e.p) || led_a !== 8'(1 << e.p) || end_a !== e.ae) begin
        errors++;
        $display("FAIL bounce[%0d]: got pos=%0d led=%b at_end=%b, want pos=%0d led=%b at_end=%b",
                 i, pos_a, led_a, end_a, e.p, 8'(1 << e.p), e.ae);
      end
    end
  endtask

  task automatic test_wrap_down();
    row_t rows[$];
    exp_t e;
    rows.push_back(mk(1, 0, 0, 0, 0, 0, 0));
    rows.push_back(mk(0, 0, 1, 0, 1, 0, 0));
    rows.push_back(mk(0, 1, 1, 0, 1, 7, 1));
    rows.push_back(mk(0, 1, 1, 0, 1, 6, 0));
    rows.push_back(mk(0, 1, 1, 0, 0, 5, 0));
    rows.push_back(mk(0, 0, 1, 0, 0, 5, 0));
    foreach (rows[i]) begin
      drive_a(rows[i]);
      e = q.pop_front();
      checks++;
      if (pos_a !== 3'(e.p) || led_a !== 8'(1 << e.p) || end_a !== e.ae) begin
        errors++;
        $display("FAIL wrap_down[%0d]: got pos=%0d led=%b at_end=%b, want pos=%0d led=%b at_end=%b",
                 i, pos_a, led_a, end_a, e.p, 8'(1 << e.p), e.ae);
      end
    end
  endtask

  task automatic test_enable_freeze();
    row_t rows[$];
    exp_t e;
    rows.push_back(mk(1, 0, 0, 0, 0, 0, 0));
    rows.push_back(mk(0, 1, 1, 1, 0, 0, 0));
    for (int p = 1; p <= 4; p++) rows.push_back(mk(0, 1, 1, 1, 0, p, 0));
    rows.push_back(mk(0, 1, 0, 1, 0, 4, 0));
    rows.push_back(mk(0, 1, 0, 1, 1, 4, 0));
    rows.push_back(mk(0, 1, 1, 1, 1, 4, 0));
    rows.push_back(mk(0, 1, 1, 1, 1, 3, 0));
    rows.push_back(mk(0, 0, 1, 1, 0, 3, 0));
    foreach (rows[i]) begin
      drive_a(rows[i]);
      e = q.pop_front();
      checks++;
      if (pos_a !== 3'(e.p) || led_a !== 8'(1 << e.p) || end_a !== e.ae) begin
        errors++;
        $display("FAIL enable_freeze[%0d]: got pos=%0d led=%b at_end=%b, want pos=%0d led=%b at_end=%b",
                 i, pos_a, led_a, end_a, e.p, 8'(1 << e.p), e.ae);
      end
    end
  endtask

  task automatic test_reset_mid_run();
    row_t rows[$];
    exp_t e;
    rows.push_back(mk(1, 0, 0, 0, 0, 0, 0));
    rows.push_back(mk(0, 0, 1, 0, 0, 0, 0));
    for (int p = 1; p <= 5; p++) rows.push_back(mk(0, 1, 1, 0, 0, p, 0));
    rows.push_back(mk(1, 1, 1, 0, 0, 0, 0));
    rows.push_back(mk(0, 1, 1, 0, 0, 0, 0));
    rows.push_back(mk(0, 1, 1, 0, 0, 1, 0));
    foreach (rows[i]) begin
      drive_a(rows[i]);
      e = q.pop_front();
      checks++;
      if (pos_a !== 3'(e.p) || led_a !== 8'(1 << e.p) || end_a !== e.ae) begin
        errors++;
        $display("FAIL reset_mid_run[%0d]: got pos=%0d led=%b at_end=%b, want pos=%0d led=%b at_end=%b",
                 i, pos_a, led_a, end_a, e.p, 8'(1 << e.p), e.ae);
      end
    end
  endtask

  task automatic test_bounce_change();
    row_t rows[$];
    exp_t e;
    rows.push_back(mk(1, 0, 0, 0, 0, 0, 0));
    rows.push_back(mk(0, 0, 1, 0, 0, 0, 0));
    for (int p = 1; p <= 7; p++) rows.push_back(mk(0, 1, 1, 0, 0, p, int'(p == 7)));
    rows.push_back(mk(0, 1, 1, 0, 0, 0, 1));
    for (int p = 1; p <= 7; p++) rows.push_back(mk(0, 1, 1, 0, 0, p, int'(p == 7)));
    rows.push_back(mk(0, 1, 1, 1, 0, 6, 0));
    for (int p = 5; p >= 0; p--) rows.push_back(mk(0, 1, 1, 0, 0, p, int'(p == 0)));
    rows.push_back(mk(0, 1, 1, 0, 0, 7, 1));
    rows.push_back(mk(0, 1, 1, 0, 0, 6, 0));
    foreach (rows[i]) begin
      drive_a(rows[i]);
      e = q.pop_front();
      checks++;
      if (pos_a !== 3'(e.p) || led_a !== 8'(1 << e.p) || end_a !== e.ae) begin
        errors++;
        $display("FAIL bounce_change[%0d]: got pos=%0d led=%b at_end=%b, want pos=%0d led=%b at_end=%b",
                 i, pos_a, led_a, end_a, e.p, 8'(1 << e.p), e.ae);
      end
    end
  endtask

  task automatic test_back_to_back_n2();
    row_t rows[$];
    exp_t e;
    rows.push_back(mk(1, 0, 0, 0, 0, 0, 0));
    rows.push_back(mk(0, 0, 1, 1, 0, 0, 0));
    rows.push_back(mk(0, 1, 1, 1, 0, 1, 1));
    rows.push_back(mk(0, 1, 1, 1, 0, 0, 1));
    rows.push_back(mk(0, 1, 1, 1, 0, 1, 1));
    rows.push_back(mk(0, 1, 1, 1, 0, 0, 1));
    rows.push_back(mk(0, 0, 1, 1, 0, 0, 0));
    rows.push_back(mk(0, 1, 1, 0, 0, 1, 1));
    rows.push_back(mk(0, 1, 1, 0, 0, 0, 1));
    foreach (rows[i]) begin
      drive_b(rows[i]);
      e = q.pop_front();
      checks++;
      if (pos_b !== 1'(e.p) || led_b !== 2'(1 << e.p) || end_b !== e.ae) begin
        errors++;
        $display("FAIL n2_back_to_back[%0d]: got pos=%0d led=%b at_end=%b, want pos=%0d led=%b at_end=%b",
                 i, pos_b, led_b, end_b, e.p, 2'(1 << e.p), e.ae);
      end
    end
  endtask

  initial begin
    {reset_a, tick_a, en_a, bounce_a, dir_a} = 5'b10000;
    {reset_b, tick_b, en_b, bounce_b, dir_b} = 5'b10000;
    @(posedge clk); #1;
    test_reset();
    test_bounce();
    test_wrap_down();
    test_enable_freeze();
    test_reset_mid_run();
    test_bounce_change();
    test_back_to_back_n2();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
